// File: rtl/subtrator_pkg.sv
// Shared types, constants and helpers for the serial add/subtract unit.
package subtrator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODO_SUB = 1'b0;
  localparam logic MODO_ADD = 1'b1;

  // Digit counter width: clog2 of the digit count, never narrower than one bit.
  function automatic int cnt_width(input int n_digits);
    if (n_digits <= 2) return 1;
    return $clog2(n_digits);
  endfunction

endpackage

// File: rtl/subtrator_digito.sv
// Combinational DIGIT-bit add/subtract slice; chain is carry (add) or borrow (sub).
module subtrator_digito
  import subtrator_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_k,
  input  logic [DIGIT-1:0] b_k,
  input  logic             chain_in,
  input  logic             modo,
  output logic [DIGIT-1:0] res_k,
  output logic             chain_out
);

  logic [DIGIT:0] ext_a;
  logic [DIGIT:0] ext_b;
  logic [DIGIT:0] ext_c;
  logic [DIGIT:0] r;

  // One extra bit holds the carry, or the borrow as the sign of the difference.
  always_comb begin
    ext_a = {1'b0, a_k};
    ext_b = {1'b0, b_k};
    ext_c = {{DIGIT{1'b0}}, chain_in};
    if (modo == MODO_ADD) r = ext_a + ext_b + ext_c;
    else                  r = ext_a - ext_b - ext_c;
    res_k     = r[DIGIT-1:0];
    chain_out = r[DIGIT];
  end

endmodule

// File: rtl/subtrator_serial_n.sv
// Digit-serial add/subtract unit with valid/ready handshakes and flags.
// Optional unsigned saturation of the final result: define SUBTRATOR_SAT_EN.
module subtrator_serial_n
  import subtrator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             modo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diferenca,
  output logic             bout,
  output logic             overflow,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             chain_q, chain_d;
  logic             modo_q, modo_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] dif_q, dif_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [DIGIT-1:0] res_k;
  logic             chain_out;
  logic [WIDTH-1:0] res_full;
  logic [WIDTH-1:0] final_res;
  logic             ovf_calc;
  logic             load;

  // Operands shift right so the current digit always sits in the low bits.
  subtrator_digito #(.DIGIT(DIGIT)) u_digito (
    .a_k      (a_q[DIGIT-1:0]),
    .b_k      (b_q[DIGIT-1:0]),
    .chain_in (chain_q),
    .modo     (modo_q),
    .res_k    (res_k),
    .chain_out(chain_out)
  );

  // New digits enter at the top, so after the last digit every slice is in place.
  assign res_full = WIDTH'({res_k, res_q} >> DIGIT);

  always_comb begin
    final_res = res_full;
`ifdef SUBTRATOR_SAT_EN
    if (chain_out) final_res = (modo_q == MODO_ADD) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
`endif
    if (modo_q == MODO_ADD)
      ovf_calc = (a_msb_q == b_msb_q) && (res_full[WIDTH-1] != a_msb_q);
    else
      ovf_calc = (a_msb_q != b_msb_q) && (res_full[WIDTH-1] != a_msb_q);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    chain_d  = chain_q;
    modo_d   = modo_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    dif_d    = dif_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    in_ready = 1'b0;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) load = 1'b1;
      end
      CALC: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_full;
        chain_d = chain_out;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          dif_d   = final_res;
          bout_d  = chain_out;
          ovf_d   = ovf_calc;
          zero_d  = (final_res == '0);
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) load = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Retiring a result and accepting the next pair share one edge.
    if (load) begin
      state_d = CALC;
      cnt_d   = '0;
      a_d     = a;
      b_d     = b;
      chain_d = bin;
      modo_d  = modo;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      chain_q <= 1'b0;
      modo_q  <= MODO_SUB;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      dif_q   <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      chain_q <= chain_d;
      modo_q  <= modo_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      dif_q   <= dif_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign diferenca = dif_q;
  assign bout      = bout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_subtrator_serial_n.sv
// Self-checking bench for subtrator_serial_n at DIGIT = 1, 4 and 8 (WIDTH = 8).
module tb_subtrator_serial_n;

  typedef struct {
    logic       modo;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] dif;
    logic       bout;
    logic       ovf;
    logic       zero;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_s;
  logic [7:0] b_s;
  logic       bin_s;
  logic       modo_s;
  logic       iv[3];
  logic       ordy[3];
  logic       ir[3];
  logic       ov[3];
  logic [7:0] dif[3];
  logic       bo[3];
  logic       ovf[3];
  logic       zr[3];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_lat[3] = '{8, 2, 1};

  subtrator_serial_n #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_s), .b(b_s), .bin(bin_s), .modo(modo_s),
    .out_valid(ov[0]), .out_ready(ordy[0]), .diferenca(dif[0]),
    .bout(bo[0]), .overflow(ovf[0]), .zero(zr[0])
  );

  subtrator_serial_n #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_s), .b(b_s), .bin(bin_s), .modo(modo_s),
    .out_valid(ov[1]), .out_ready(ordy[1]), .diferenca(dif[1]),
    .bout(bo[1]), .overflow(ovf[1]), .zero(zr[1])
  );

  subtrator_serial_n #(.WIDTH(8), .DIGIT(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_s), .b(b_s), .bin(bin_s), .modo(modo_s),
    .out_valid(ov[2]), .out_ready(ordy[2]), .diferenca(dif[2]),
    .bout(bo[2]), .overflow(ovf[2]), .zero(zr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, signed overflow as a range check.
  function automatic vec_t refModel(input logic [7:0] a, input logic [7:0] b,
                                    input logic bin, input logic modo);
    vec_t v;
    int   ures;
    int   sres;
    v.modo = modo; v.a = a; v.b = b; v.bin = bin;
    if (modo) begin
      ures = int'(a) + int'(b) + int'(bin);
      sres = int'($signed(a)) + int'($signed(b)) + int'(bin);
      v.bout = (ures > 255);
    end else begin
      ures = int'(a) - int'(b) - int'(bin);
      sres = int'($signed(a)) - int'($signed(b)) - int'(bin);
      v.bout = (ures < 0);
    end
    v.dif = 8'(ures);
    v.ovf = (sres > 127) || (sres < -128);
`ifdef SUBTRATOR_SAT_EN
    if (v.bout) v.dif = modo ? 8'hFF : 8'h00;
`endif
    v.zero = (v.dif == 8'h00);
    return v;
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s (dut%0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic checkResult(input int idx, input vec_t v, input string tag);
    checkOutput({tag, " diferenca"}, idx, 32'(dif[idx]), 32'(v.dif));
    checkOutput({tag, " bout"},      idx, 32'(bo[idx]),  32'(v.bout));
    checkOutput({tag, " overflow"},  idx, 32'(ovf[idx]), 32'(v.ovf));
    checkOutput({tag, " zero"},      idx, 32'(zr[idx]),  32'(v.zero));
  endtask

  task automatic waitValid(input int idx, input int budget, output int cycles);
    cycles = 0;
    while (!ov[idx] && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!ov[idx]) cycles = -1;
  endtask

  // One transaction on all three instances, then scrambled inputs during CALC.
  task automatic applyStimulus(input vec_t v, input string tag);
    int lat[3];
    @(posedge clk); #1;
    a_s = v.a; b_s = v.b; bin_s = v.bin; modo_s = v.modo;
    for (int i = 0; i < 3; i++) begin iv[i] = 1'b1; ordy[i] = 1'b0; end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      checkOutput({tag, " in_ready busy"}, i, 32'(ir[i]), 32'd0);
    end
    a_s = 8'($urandom); b_s = 8'($urandom);
    bin_s = 1'($urandom); modo_s = 1'($urandom);
    lat = '{-1, -1, -1};
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) if (ov[i] && lat[i] < 0) lat[i] = c;
      if (lat[0] > 0 && lat[1] > 0 && lat[2] > 0) break;
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput({tag, " latency"}, i, 32'(lat[i]), 32'(exp_lat[i]));
      checkResult(i, v, tag);
      ordy[i] = 1'b1;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput({tag, " out_valid retire"}, i, 32'(ov[i]), 32'd0);
      ordy[i] = 1'b0;
    end
  endtask

  initial begin
    vec_t tbl[8];
    vec_t v;
    int   c;

    tbl[0] = '{1'b0, 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0};
`ifdef SUBTRATOR_SAT_EN
    tbl[1] = '{1'b0, 8'h05, 8'h07, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'hFF, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
`else
    tbl[1] = '{1'b0, 8'h05, 8'h07, 1'b1, 8'hFD, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
`endif
    tbl[2] = '{1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};

    a_s = '0; b_s = '0; bin_s = 1'b0; modo_s = 1'b0;
    for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ordy[i] = 1'b0; end
    rst_n = 1'b0;
    #22;
    for (int i = 0; i < 3; i++) begin
      checkOutput("reset in_ready", i, 32'(ir[i]), 32'd1);
      checkOutput("reset out_valid", i, 32'(ov[i]), 32'd0);
      checkResult(i, '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}, "reset");
    end
    rst_n = 1'b1;

    for (int t = 0; t < 8; t++) applyStimulus(tbl[t], $sformatf("table[%0d]", t));

    for (int t = 0; t < 40; t++) begin
      v = refModel(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      applyStimulus(v, $sformatf("random[%0d]", t));
    end

    // Back-to-back on the DIGIT=1 instance: no IDLE cycle between results.
    @(posedge clk); #1;
    a_s = 8'h10; b_s = 8'h10; bin_s = 1'b0; modo_s = 1'b0;
    iv[0] = 1'b1; ordy[0] = 1'b1;
    @(posedge clk); #1;
    a_s = 8'h80; b_s = 8'h01;
    waitValid(0, 20, c);
    checkOutput("b2b first latency", 0, 32'(c), 32'd8);
    checkOutput("b2b first zero", 0, 32'(zr[0]), 32'd1);
    checkOutput("b2b first diferenca", 0, 32'(dif[0]), 32'h00);
    checkOutput("b2b in_ready in DONE", 0, 32'(ir[0]), 32'd1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    checkOutput("b2b out_valid after retire", 0, 32'(ov[0]), 32'd0);
    checkOutput("b2b no IDLE bubble", 0, 32'(ir[0]), 32'd0);
    waitValid(0, 20, c);
    checkOutput("b2b second latency", 0, 32'(c), 32'd8);
    checkOutput("b2b second diferenca", 0, 32'(dif[0]), 32'h7F);
    checkOutput("b2b second overflow", 0, 32'(ovf[0]), 32'd1);
    @(posedge clk); #1;
    checkOutput("b2b final retire", 0, 32'(ov[0]), 32'd0);
    ordy[0] = 1'b0;

    // Backpressure: result held while out_ready is low, new operands refused.
    @(posedge clk); #1;
    a_s = 8'h35; b_s = 8'h12; bin_s = 1'b0; modo_s = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    waitValid(0, 20, c);
    checkOutput("bp latency", 0, 32'(c), 32'd8);
    a_s = 8'hAA; b_s = 8'h55; iv[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp out_valid held", 0, 32'(ov[0]), 32'd1);
      checkOutput("bp in_ready low", 0, 32'(ir[0]), 32'd0);
      checkResult(0, tbl[0], "bp hold");
      @(posedge clk); #1;
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp release out_valid", 0, 32'(ov[0]), 32'd0);
    checkOutput("bp release in_ready", 0, 32'(ir[0]), 32'd1);
    checkResult(0, tbl[0], "bp after retire");
    ordy[0] = 1'b0;

    // Reset during the third CALC cycle aborts the operation at once.
    @(posedge clk); #1;
    a_s = 8'h55; b_s = 8'h22; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset in_ready", 0, 32'(ir[0]), 32'd1);
    checkOutput("midreset out_valid", 0, 32'(ov[0]), 32'd0);
    checkResult(0, '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}, "midreset");
    #3;
    rst_n = 1'b1;
    applyStimulus('{1'b0, 8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0}, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
